oam_dma: RTL and testbench

Sprite-attribute DMA engine sitting directly upstream of the PPU's sprite table at FE00–FE9F. A CPU store to FF46 latches a source page. The engine then copies 160 bytes, one at a time, from page `src`*0x100 onto the PPU's sprite-memory write port. It paces each byte at a fixed cycle count, flags `busy` for the whole transfer, and exposes FF46 on the shared OR-combined read bus.

---
 rtl/oam_dma.sv | 120 ++++++++++++
 tb/tb_oam_dma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: an FF46 store copies OAM_BYTES bytes from a source page to FE00+, one byte per BYTE_CYCLES clocks.
// Optional feature macro OAM_DMA_BLOCK_EN adds CPU bus blocking (cpu_block) during a transfer.
module oam_dma #(
  parameter int BYTE_CYCLES = 4,
  parameter int OAM_BYTES   = 160
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  output logic        dma_load,
  input  logic [7:0]  dma_data,
  output logic [15:0] oam_address,
  output logic [7:0]  oam_data,
  output logic        oam_store,
  output logic        busy,
  output logic        done,
  output logic        cpu_block
);

  localparam int CW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BYTE_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST = 8'(OAM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, WAIT} state_t;

  state_t        state;
  logic [7:0]    src;
  logic [7:0]    idx;
  logic [CW-1:0] cyc;
  logic [7:0]    page;
  logic          reg_hit;
  logic          last_byte;

  // Echo pages E0-FF land on the C000 work-RAM shadow.
  function automatic logic [7:0] fold_page(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  assign page      = fold_page(src);
  assign reg_hit   = (address == 16'hFF46);
  assign last_byte = (idx == IDX_LAST);

`ifdef OAM_DMA_BLOCK_EN
  assign cpu_block = busy && !((address >= 16'hFF80) && (address <= 16'hFFFE));
`else
  assign cpu_block = 1'b0;
`endif

  // Source data arrives the clock after dma_load, i.e. during WRITE, so it passes straight through.
  assign oam_data = (state == WRITE) ? dma_data : 8'h00;

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state       <= IDLE;
      src         <= 8'hFF;
      idx         <= 8'h00;
      cyc         <= '0;
      outdata     <= 8'h00;
      dma_address <= 16'h0000;
      dma_load    <= 1'b0;
      oam_address <= 16'h0000;
      oam_store   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      dma_load  <= 1'b0;
      oam_store <= 1'b0;
      done      <= 1'b0;
      outdata   <= (load && reg_hit) ? (cpu_block ? 8'hFF : src) : 8'h00;

      if (store && reg_hit) begin
        // A new store always (re)starts from SETUP, abandoning any transfer in flight.
        src   <= indata;
        state <= SETUP;
        busy  <= 1'b1;
        idx   <= 8'h00;
        cyc   <= '0;
      end else begin
        case (state)
          IDLE: ;
          SETUP: begin
            state       <= READ;
            cyc         <= '0;
            dma_load    <= 1'b1;
            dma_address <= {page, idx};
          end
          READ, WRITE, WAIT: begin
            if (cyc == CYC_LAST) begin
              if (last_byte) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state       <= READ;
                cyc         <= '0;
                idx         <= idx + 8'd1;
                dma_load    <= 1'b1;
                dma_address <= {page, idx + 8'd1};
              end
            end else begin
              cyc   <= cyc + CW'(1);
              state <= (state == READ) ? WRITE : WAIT;
              if (state == READ) begin
                oam_store   <= 1'b1;
                oam_address <= 16'hFE00 + {8'h00, idx};
              end
              if (last_byte && ((cyc + CW'(1)) == CYC_LAST)) done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected source reads and sprite writes are queued at each FF46 store.
module tb_oam_dma;

`ifdef OAM_DMA_BLOCK_EN
  localparam logic BLK = 1'b1;
`else
  localparam logic BLK = 1'b0;
`endif

  logic        clockgb = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic [15:0] dma_address;
  logic        dma_load;
  logic [7:0]  dma_data = 8'h00;
  logic [15:0] oam_address;
  logic [7:0]  oam_data;
  logic        oam_store;
  logic        busy;
  logic        done;
  logic        cpu_block;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt, done_cnt, busy_run, last_busy;
  logic [23:0] last_wr;
  logic [15:0] q_dma[$];
  logic [23:0] q_oam[$];

  oam_dma dut (
    .clockgb(clockgb), .reset(reset), .address(address), .indata(indata),
    .outdata(outdata), .load(load), .store(store), .dma_address(dma_address),
    .dma_load(dma_load), .dma_data(dma_data), .oam_address(oam_address),
    .oam_data(oam_data), .oam_store(oam_store), .busy(busy), .done(done),
    .cpu_block(cpu_block)
  );

  always #5 clockgb = ~clockgb;

  // Source memory: low address byte XOR 5A, one clock read latency.
  always @(posedge clockgb) if (dma_load) dma_data <= dma_address[7:0] ^ 8'h5A;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clockgb) begin
    if (dma_load) begin
      if (q_dma.size() == 0) chk("dma_extra", 32'(q_dma.size()), 32'd1);
      else chk("dma_addr", {16'h0, dma_address}, {16'h0, q_dma.pop_front()});
    end
    if (oam_store) begin
      wr_cnt++;
      last_wr = {oam_address, oam_data};
      if (q_oam.size() == 0) chk("oam_extra", 32'(q_oam.size()), 32'd1);
      else chk("oam_write", {8'h0, oam_address, oam_data}, {8'h0, q_oam.pop_front()});
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_last", 32'(q_oam.size()), 32'd0);
    end
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy = busy_run;
      busy_run = 0;
    end
  end

  task automatic push_xfer(input logic [7:0] pg);
    for (int i = 0; i < 160; i++) begin
      q_dma.push_back({pg, 8'(i)});
      q_oam.push_back({16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; last_busy = 0;
  endtask

  task automatic ff46_store(input logic [7:0] v);
    address = 16'hFF46; indata = v; store = 1'b1;
    @(posedge clockgb); #1;
    store = 1'b0; address = 16'h0000;
  endtask

  task automatic ff46_read(output logic [7:0] v);
    address = 16'hFF46; load = 1'b1;
    @(posedge clockgb); #1;
    load = 1'b0; address = 16'h0000;
    v = outdata;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin @(negedge clockgb); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(posedge clockgb); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {outdata, dma_address, oam_data}, 32'h0);
    chk({tag, "_oamaddr"}, 32'(oam_address), 32'h0);
    chk({tag, "_ctl"}, {27'h0, dma_load, oam_store, busy, done, cpu_block}, 32'h0);
  endtask

  initial begin
    logic [7:0] rd;
    logic seen;
    reset = 1'b1; address = 16'h0; indata = 8'h0; load = 1'b0; store = 1'b0;
    busy_run = 0;
    clear_stats();
    repeat (3) @(posedge clockgb);
    #1 reset = 1'b0;
    @(negedge clockgb);
    chk_all_zero("reset");
    @(posedge clockgb); #1;
    ff46_read(rd);
    chk("rd_reset", 32'(rd), 32'hFF);
    @(posedge clockgb); #1;
    chk("rd_release", 32'(outdata), 32'h0);

    // Full transfer from C1xx with timing of the first byte and bus blocking mid-transfer
    clear_stats();
    push_xfer(8'hC1);
    ff46_store(8'hC1);
    @(negedge clockgb);
    chk("setup", {30'h0, busy, dma_load}, 32'h2);
    @(negedge clockgb);
    chk("rd0_strobe", 32'(dma_load), 32'd1);
    chk("rd0_addr", 32'(dma_address), 32'hC100);
    @(negedge clockgb);
    chk("wr0", {7'h0, oam_store, oam_address, oam_data}, {7'h0, 1'b1, 16'hFE00, 8'h5A});
    @(posedge clockgb); #1;
    address = 16'hC000; #1;
    chk("blk_c000", 32'(cpu_block), 32'(BLK));
    address = 16'hFF80; #1;
    chk("blk_ff80", 32'(cpu_block), 32'd0);
    @(posedge clockgb); #1;
    ff46_read(rd);
    chk("rd_busy", 32'(rd), BLK ? 32'hFF : 32'hC1);
    wait_idle(800);
    chk("c1_busy_len", 32'(last_busy), 32'd641);
    chk("c1_done", 32'(done_cnt), 32'd1);
    chk("c1_writes", 32'(wr_cnt), 32'd160);
    chk("c1_last_wr", {8'h0, last_wr}, {8'h0, 16'hFE9F, 8'hC5});
    chk("c1_drain", 32'(q_dma.size() + q_oam.size()), 32'd0);
    ff46_read(rd);
    chk("rd_after", 32'(rd), 32'hC1);

    // Echo page FE folds to DE
    clear_stats();
    push_xfer(8'hDE);
    ff46_store(8'hFE);
    wait_idle(800);
    chk("fe_done", 32'(done_cnt), 32'd1);
    chk("fe_writes", 32'(wr_cnt), 32'd160);
    chk("fe_busy_len", 32'(last_busy), 32'd641);
    chk("fe_drain", 32'(q_dma.size() + q_oam.size()), 32'd0);

    // Restart during byte 50 WAIT
    clear_stats();
    push_xfer(8'hC0);
    ff46_store(8'hC0);
    repeat (203) @(posedge clockgb);
    #1;
    chk("ab_wait", {29'h0, busy, dma_load, oam_store}, 32'h4);
    chk("ab_partial", 32'(wr_cnt), 32'd51);
    ff46_store(8'hD0);
    q_dma.delete();
    q_oam.delete();
    push_xfer(8'hD0);
    @(negedge clockgb);
    chk("ab_setup", {30'h0, busy, dma_load}, 32'h2);
    @(negedge clockgb);
    chk("ab_restart", {15'h0, dma_load, dma_address}, {15'h0, 1'b1, 16'hD000});
    wait_idle(800);
    chk("ab_done", 32'(done_cnt), 32'd1);
    chk("ab_writes", 32'(wr_cnt), 32'd211);
    chk("ab_busy_len", 32'(last_busy), 32'd845);
    chk("ab_drain", 32'(q_dma.size() + q_oam.size()), 32'd0);

    // Reset during byte 80 WRITE
    push_xfer(8'hC1);
    ff46_store(8'hC1);
    repeat (322) @(posedge clockgb);
    #1;
    chk("rst_at_wr80", {15'h0, oam_store, oam_address}, {15'h0, 1'b1, 16'hFE50});
    reset = 1'b1;
    @(posedge clockgb); #1;
    reset = 1'b0;
    chk_all_zero("rst_mid");
    q_dma.delete();
    q_oam.delete();
    ff46_read(rd);
    chk("rst_src", 32'(rd), 32'hFF);

    // Reset wins over a simultaneous FF46 store
    address = 16'hFF46; indata = 8'h33; store = 1'b1; reset = 1'b1;
    @(posedge clockgb); #1;
    store = 1'b0; reset = 1'b0; address = 16'h0000;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clockgb);
      if (busy || dma_load || oam_store) seen = 1'b1;
    end
    chk("rst_store_idle", 32'(seen), 32'd0);
    @(posedge clockgb); #1;
    ff46_read(rd);
    chk("rst_store_src", 32'(rd), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
